// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle mult/div scheduler owning HI/LO, with the D-stage stall request.
// Results are computed at issue and held in pend_* until the latency down-counter expires.
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op_E,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_D,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          start, is_mul;
    logic [63:0]   smul, umul, res;
    logic [31:0]   a_abs, b_abs, uq, ur, aq, ar, sq, sr;

    assign busy      = cnt_q != '0;
    assign is_mul    = op_E == 4'd1 || op_E == 4'd2;
    assign start     = !busy && op_E >= 4'd1 && op_E <= 4'd4;
    assign stall_req = md_D & (busy | start);
    assign rdata     = (op_E == 4'd5) ? hi_q : (op_E == 4'd6) ? lo_q : 32'd0;
    assign hi        = hi_q;
    assign lo        = lo_q;

    assign smul  = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign umul  = {32'd0, rs_data} * {32'd0, rt_data};
    assign uq    = rs_data / rt_data;
    assign ur    = rs_data % rt_data;
    // Signed divide via magnitudes; 0x80000000 / -1 falls out as lo=0x80000000, hi=0.
    assign a_abs = rs_data[31] ? -rs_data : rs_data;
    assign b_abs = rt_data[31] ? -rt_data : rt_data;
    assign aq    = a_abs / b_abs;
    assign ar    = a_abs % b_abs;
    assign sq    = (rs_data[31] ^ rt_data[31]) ? -aq : aq;
    assign sr    = rs_data[31] ? -ar : ar;
    assign res   = (op_E == 4'd1) ? smul :
                   (op_E == 4'd2) ? umul :
                   (rt_data == 32'd0) ? {hi_q, lo_q} :
                   (op_E == 4'd3) ? {sr, sq} : {ur, uq};

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (busy) begin
            cnt_d = cnt_q - 1'b1;
            hi_d  = (cnt_q == CW'(1)) ? pend_hi_q : hi_q;
            lo_d  = (cnt_q == CW'(1)) ? pend_lo_q : lo_q;
        end else if (start) begin
            cnt_d     = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_hi_d = res[63:32];
            pend_lo_d = res[31:0];
        end else begin
            hi_d = (op_E == 4'd7) ? rs_data : hi_q;
            lo_d = (op_E == 4'd8) ? rs_data : lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end
endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: edge-counting reference model checked every cycle, plus directed literal expectations.
module tb_mdu_sched;
    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  op_E = 4'd1;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        md_D = 1'b0;
    logic        busy, stall_req;
    logic [31:0] rdata, hi, lo;

    mdu_sched #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset), .op_E(op_E), .rs_data(rs_data), .rt_data(rt_data),
        .md_D(md_D), .busy(busy), .stall_req(stall_req), .rdata(rdata), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: a started op finishes at edge start_edge+LAT; busy while the latest edge is before that.
    int          edge_n = 0, end_edge = 0;
    logic [31:0] hi_m = '0, lo_m = '0, phi_m = '0, plo_m = '0;
    logic        model_en = 1'b0;

    function automatic logic [63:0] compute(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
        int sa, sb;
        longint p;
        sa = a;
        sb = b;
        if (op == 4'd1) begin
            p = longint'(sa) * longint'(sb);
            return p;
        end
        if (op == 4'd2) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {h, l};
        if (op == 4'd4) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    always @(posedge clk) begin
        logic was_busy;
        logic [63:0] r;
        was_busy = edge_n < end_edge;
        edge_n++;
        if (reset) begin
            hi_m = '0; lo_m = '0; phi_m = '0; plo_m = '0;
            end_edge = 0;
            model_en = 1'b1;
        end else if (was_busy) begin
            if (op_E >= 4'd1 && op_E <= 4'd8) begin
                n_total++;
                $display("FAIL protocol: op %0d issued while busy", op_E);
            end
            if (edge_n == end_edge) begin
                hi_m = phi_m;
                lo_m = plo_m;
            end
        end else if (op_E >= 4'd1 && op_E <= 4'd4) begin
            r = compute(op_E, rs_data, rt_data, hi_m, lo_m);
            phi_m = r[63:32];
            plo_m = r[31:0];
            end_edge = edge_n + ((op_E <= 4'd2) ? MULT : DIV);
        end else if (op_E == 4'd7) hi_m = rs_data;
        else if (op_E == 4'd8) lo_m = rs_data;
    end

    always @(negedge clk) begin
        logic bm, st;
        if (model_en) begin
            bm = edge_n < end_edge;
            st = !bm && op_E >= 4'd1 && op_E <= 4'd4;
            chk("busy", {31'd0, busy}, {31'd0, bm});
            chk("stall_req", {31'd0, stall_req}, {31'd0, md_D & (bm | st)});
            chk("rdata", rdata, (op_E == 4'd5) ? hi_m : (op_E == 4'd6) ? lo_m : 32'd0);
            chk("hi", hi, hi_m);
            chk("lo", lo, lo_m);
        end
    end

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic md);
        op_E = op; rs_data = a; rt_data = b; md_D = md;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic md);
        for (int i = 0; i < n; i++) step(4'd0, '0, '0, md);
    endtask

    initial begin
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(4'd0, '0, '0, 1'b0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        idle(8, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        md_D = 1'b1; op_E = 4'd1; rs_data = 32'hFFFF_FFFE; rt_data = 32'd3;
        #1;
        chk("mult_stall_t", {31'd0, stall_req}, 32'd1);
        @(posedge clk);
        #2;
        chk("mult_busy_t1", {31'd0, busy}, 32'd1);
        idle(4, 1'b1);
        chk("mult_busy_t5", {31'd0, busy}, 32'd1);
        chk("mult_stall_t5", {31'd0, stall_req}, 32'd1);
        idle(1, 1'b1);
        chk("mult_busy_t6", {31'd0, busy}, 32'd0);
        chk("mult_stall_t6", {31'd0, stall_req}, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        step(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(5, 1'b0);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(9, 1'b0);
        chk("div_busy_10", {31'd0, busy}, 32'd1);
        idle(1, 1'b0);
        chk("div_busy_done", {31'd0, busy}, 32'd0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        step(4'd7, 32'h11, '0, 1'b0);
        step(4'd8, 32'h22, '0, 1'b0);
        step(4'd4, 32'd7, 32'd0, 1'b0);
        idle(9, 1'b0);
        chk("divu0_busy", {31'd0, busy}, 32'd1);
        idle(1, 1'b0);
        chk("divu0_hi", hi, 32'h11);
        chk("divu0_lo", lo, 32'h22);

        step(4'd7, 32'hDEAD_BEEF, '0, 1'b1);
        op_E = 4'd6; #1;
        chk("mflo_rdata", rdata, 32'h22);
        @(posedge clk); #2;
        op_E = 4'd5; #1;
        chk("mfhi_rdata", rdata, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        step(4'd8, 32'h5555_AAAA, '0, 1'b0);
        chk("mtlo_lo", lo, 32'h5555_AAAA);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);

        step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV, 1'b0);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
        step(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        idle(DIV, 1'b0);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'd1);
        step(4'd4, 32'hFFFF_FFFF, 32'd16, 1'b0);
        idle(DIV, 1'b0);
        chk("divu_lo", lo, 32'h0FFF_FFFF);
        chk("divu_hi", hi, 32'd15);

        step(4'd3, 32'd100, 32'd7, 1'b1);
        idle(3, 1'b1);
        reset = 1'b1;
        step(4'd0, '0, '0, 1'b1);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        idle(12, 1'b0);
        chk("abort_no_commit_hi", hi, 32'd0);
        chk("abort_no_commit_lo", lo, 32'd0);

        idle(2, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide scheduler owning the HI/LO architectural registers for the 5-stage MIPS pipeline.
- Accepts MDU operations from the E stage and models the fixed mult/div latency with a down-counter.
- Commits 64-bit results to HI/LO at completion.
- Produces the busy/stall request consumed by the stall unit, and serves mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op_E  input  4  MDU op in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- rs_data  input  32  forwarded rs value in E.
- rt_data  input  32  forwarded rt value in E.
- md_D  input  1  D-stage instruction is any MDU op (1-8), from the D decoder.
- busy  output  1  operation in flight.
- stall_req  output  1  hold D stage, to the stall unit.
- rdata  output  32  HI for op 5, LO for op 6, else 0; combinational.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- State: cnt (4+ bits, wide enough for max(MULT_CYCLES, DIV_CYCLES)), hi, lo, pend_hi, pend_lo.
- busy = (cnt != 0). FSM is implicit: IDLE (cnt==0) and RUN (cnt>0).
- start = op_E in {1,2,3,4} and not busy.
- stall_req = md_D & (busy | start). It must be combinational; it is the only back-pressure mechanism.
- Reset:
  - cnt, hi, lo, pend_hi and pend_lo clear to 0.
  - busy=0, stall_req=md_D & start (0 when op_E is none), rdata=0.
  - Reset mid-operation aborts it; HI/LO stay 0 and no commit follows.
- IDLE + start at edge of cycle t:
  - Compute the result combinationally from rs_data/rt_data and latch it into pend_hi/pend_lo.
  - cnt <= MULT_CYCLES or DIV_CYCLES.
- Arithmetic:
  - mult: {pend_hi, pend_lo} = signed 32x32 -> 64.
  - multu: unsigned 32x32 -> 64.
  - div: pend_lo = signed quotient truncated toward zero; pend_hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero: latch the current hi/lo into pend, so HI/LO remain unchanged at commit. Latency is still DIV_CYCLES.
  - Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- RUN: cnt decrements each cycle. On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, cnt<=0.
- Timing: start sampled at edge of cycle t gives busy=1 in cycles t+1..t+LAT (exactly LAT cycles). New HI/LO are visible from cycle t+LAT+1, when busy=0.
- mthi/mtlo (op 7/8) in IDLE write rs_data to hi/lo at the edge, one-cycle visibility.
- mfhi/mflo read the registers directly. There is no forwarding of pend values.
- Any op_E arriving while busy (start, mt*, or mf*) is ignored; the stall guarantees this never occurs legally. The bench flags it as a protocol violation but the RTL must stay coherent.
- No flush input: an MDU op that reached E always completes.

Test Plan:
- Reset: assert reset 1 cycle with op_E=1 -> busy=0, hi=lo=0, no commit afterwards.
- mult: rs=0xFFFFFFFE (-2), rt=3 at cycle t.
  - busy high t+1..t+5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA at t+6.
  - md_D=1 during t..t+5 gives stall_req=1, dropping at t+6.
- multu: same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- div/divu:
  - div rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy exactly 10 cycles.
  - divu rs=7, rt=0 with prior hi=0x11, lo=0x22 -> unchanged after 10 busy cycles.
- Move ops: mthi rs=0xDEADBEEF, then mflo/mfhi next cycles -> rdata=lo then 0xDEADBEEF.
  - mtlo with busy=0 -> lo updated next cycle, busy stays 0.
- Reset mid-op: start div, assert reset at busy cycle 4 -> busy=0 next cycle, hi=lo=0, no later commit.
